// File: rtl/pattern_store_pkg.sv
// pattern_store_pkg: shared widths, types and FSM states for the pattern store.
package pattern_store_pkg;
  localparam int D_WIDTH      = 8;
  localparam int BUFP_WIDTH   = 3;
  localparam int FIELDP_WIDTH = 5;
  localparam int A_WIDTH      = BUFP_WIDTH + FIELDP_WIDTH;
  typedef logic [D_WIDTH-1:0] field_t;
  typedef logic [A_WIDTH-1:0] buf_fieldp_t;
  typedef enum logic [1:0] {IDLE, LOAD, UNLOAD} pstore_state_e;
endpackage

// File: rtl/pattern_store_mem.sv
// pattern_store_mem: flop array with async reads, one sync write port and sync clear (second read port with PATSTORE_UNLOAD_EN).
module pattern_store_mem
  import pattern_store_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  buf_fieldp_t raddr_a,
  output field_t      rdata_a,
`ifdef PATSTORE_UNLOAD_EN
  input  buf_fieldp_t raddr_b,
  output field_t      rdata_b,
`endif
  input  logic        we,
  input  buf_fieldp_t waddr,
  input  field_t      wdata
);
  field_t mem [2**A_WIDTH];
  assign rdata_a = mem[raddr_a];
`ifdef PATSTORE_UNLOAD_EN
  assign rdata_b = mem[raddr_b];
`endif
  always_ff @(posedge clk)
    if (!reset) begin
      for (int i = 0; i < 2**A_WIDTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
endmodule

// File: rtl/pattern_store.sv
// pattern_store: PAT field store with host load port; PATSTORE_UNLOAD_EN adds the unload stream.
module pattern_store
  import pattern_store_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  buf_fieldp_t              buf_fieldp,
  output field_t                   field_out,
  input  buf_fieldp_t              buf_fieldwp,
  input  logic                     field_write_en,
  input  field_t                   field_in,
  input  logic                     ld_start,
  input  logic [BUFP_WIDTH-1:0]    ld_buf,
  input  logic                     ld_valid,
  input  field_t                   ld_data,
  output logic                     ld_ready,
  output logic                     ld_busy,
  output logic                     ld_done,
  output logic [2**BUFP_WIDTH-1:0] buf_lock
`ifdef PATSTORE_UNLOAD_EN
  ,
  input  logic                     ul_start,
  input  logic [BUFP_WIDTH-1:0]    ul_buf,
  input  logic                     ul_ready,
  output logic                     ul_valid,
  output field_t                   ul_data
`endif
);
  pstore_state_e state, state_nxt;
  logic [FIELDP_WIDTH-1:0] cnt, cnt_nxt;
  logic [BUFP_WIDTH-1:0] bsel, bsel_nxt;
  logic ld_beat, beat, last, we;
  buf_fieldp_t waddr;
  field_t wdata;
  assign ld_ready = state == LOAD && !field_write_en;
  assign ld_beat  = ld_valid && ld_ready;
  assign last     = beat && cnt == '1;
  assign ld_busy  = state != IDLE;
  assign buf_lock = {{(2**BUFP_WIDTH-1){1'b0}}, ld_busy} << bsel;
  // PAT owns the single write port whenever it strobes; the host simply stalls
  assign we    = field_write_en || ld_beat;
  assign waddr = field_write_en ? buf_fieldwp : {bsel, cnt};
  assign wdata = field_write_en ? field_in : ld_data;
`ifdef PATSTORE_UNLOAD_EN
  logic ul_go, ul_beat;
  field_t ul_rdata;
  assign ul_go   = state == IDLE && ul_start && !ld_start;
  assign ul_beat = ul_valid && ul_ready;
  assign beat    = ld_beat || ul_beat;
`else
  assign beat = ld_beat;
`endif
  always_comb begin
    state_nxt = last ? IDLE : state;
    cnt_nxt   = beat ? cnt + 1'b1 : cnt;
    bsel_nxt  = bsel;
    if (state == IDLE && ld_start) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
      bsel_nxt  = ld_buf;
    end
`ifdef PATSTORE_UNLOAD_EN
    else if (ul_go) begin
      state_nxt = UNLOAD;
      cnt_nxt   = '0;
      bsel_nxt  = ul_buf;
    end
`endif
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bsel    <= '0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bsel    <= bsel_nxt;
      ld_done <= last;
    end
`ifdef PATSTORE_UNLOAD_EN
  // Prefetch the field the counter moves to, so ul_data is ready the cycle after each handshake
  always_ff @(posedge clk)
    if (!reset) begin
      ul_valid <= 1'b0;
      ul_data  <= '0;
    end else begin
      ul_valid <= ul_go || (ul_valid && !last);
      if (ul_go || ul_beat) ul_data <= ul_rdata;
    end
`endif
  pattern_store_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (buf_fieldp),
    .rdata_a (field_out),
`ifdef PATSTORE_UNLOAD_EN
    .raddr_b ({bsel_nxt, cnt_nxt}),
    .rdata_b (ul_rdata),
`endif
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata)
  );
endmodule

// File: tb/tb_pattern_store.sv
// tb_pattern_store: self-checking bench for pattern_store; unload checks compiled with PATSTORE_UNLOAD_EN.
module tb_pattern_store;
  import pattern_store_pkg::*;
  typedef struct { buf_fieldp_t a; field_t d; } rec_t;
  logic clk = 0;
  logic reset = 0;
  buf_fieldp_t buf_fieldp = '0, buf_fieldwp = '0;
  logic field_write_en = 0;
  field_t field_in = '0, field_out, ld_data = '0;
  logic ld_start = 0, ld_valid = 0, ld_ready, ld_busy, ld_done;
  logic [2:0] ld_buf = '0;
  logic [7:0] buf_lock;
`ifdef PATSTORE_UNLOAD_EN
  logic ul_start = 0, ul_ready = 0, ul_valid;
  logic [2:0] ul_buf = '0;
  field_t ul_data;
`endif
  int checks = 0, errors = 0;
  field_t model [256];
  rec_t sbq [$];
  rec_t tbl [5];

  always #5 clk = ~clk;

  pattern_store dut (
    .clk(clk), .reset(reset),
    .buf_fieldp(buf_fieldp), .field_out(field_out),
    .buf_fieldwp(buf_fieldwp), .field_write_en(field_write_en), .field_in(field_in),
    .ld_start(ld_start), .ld_buf(ld_buf), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .buf_lock(buf_lock)
`ifdef PATSTORE_UNLOAD_EN
    , .ul_start(ul_start), .ul_buf(ul_buf), .ul_ready(ul_ready), .ul_valid(ul_valid), .ul_data(ul_data)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rec_t r;
    while (sbq.size() > 0) begin
      r = sbq.pop_front();
      buf_fieldp = r.a;
      #1 chk("pat_read", field_out, r.d);
    end
  endtask

  // Stream 32 beats into buffer b; PAT writes into buffer 7 during cycles [fs, fs+fl)
  task automatic load(input logic [2:0] b, input field_t base, input int fs, input int fl);
    int i = 0, cyc = 0;
    logic fwe;
    logic [7:0] lk = 8'd1 << b;
    ld_start = 1;
    ld_buf = b;
    step();
    ld_start = 0;
    #1;
    chk("ld_busy", ld_busy, 1);
    chk("buf_lock", buf_lock, lk);
    while (i < 32 && cyc < 200) begin
      fwe = cyc >= fs && cyc < fs + fl;
      field_write_en = fwe;
      buf_fieldwp = {3'd7, 5'(cyc)};
      field_in = 8'hA0 + 8'(cyc);
      ld_valid = 1;
      ld_data = base + 8'(i);
      #1 chk("ld_ready", ld_ready, !fwe);
      if (fwe) begin
        model[buf_fieldwp] = field_in;
        sbq.push_back('{buf_fieldwp, field_in});
      end else begin
        model[{b, 5'(i)}] = ld_data;
        sbq.push_back('{{b, 5'(i)}, ld_data});
        i++;
      end
      step();
      cyc++;
    end
    ld_valid = 0;
    field_write_en = 0;
    #1;
    chk("ld_beats", i, 32);
    chk("ld_done", ld_done, 1);
    chk("ld_busy_end", ld_busy, 0);
    chk("buf_lock_end", buf_lock, 0);
    step();
    chk("ld_done_pulse", ld_done, 0);
    drain();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) model[k] = '0;
    tbl[0] = '{8'h45, 8'h2A};
    tbl[1] = '{8'h45, 8'h55};
    tbl[2] = '{8'h00, 8'hFF};
    tbl[3] = '{8'hFF, 8'h01};
    tbl[4] = '{8'h80, 8'h7E};
    // Reset state
    repeat (2) step();
    reset = 1;
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_ld_done", ld_done, 0);
    chk("rst_buf_lock", buf_lock, 0);
    for (int k = 0; k < 256; k++) begin
      buf_fieldp = 8'(k);
      #1 chk("rst_read", field_out, 0);
    end
    step();
    // PAT write: same-cycle read returns the old value, next cycle the new one
    for (int k = 0; k < 5; k++) begin
      field_write_en = 1;
      buf_fieldwp = tbl[k].a;
      field_in = tbl[k].d;
      buf_fieldp = tbl[k].a;
      #1 chk("pat_old", field_out, model[tbl[k].a]);
      step();
      field_write_en = 0;
      #1 chk("pat_new", field_out, tbl[k].d);
      model[tbl[k].a] = tbl[k].d;
    end
    // Clean load of buffer 3
    load(3'd3, 8'h10, 1000, 0);
`ifdef PATSTORE_UNLOAD_EN
    begin
      int cyc = 0;
      ul_start = 1;
      ul_buf = 3'd3;
      step();
      ul_start = 0;
      #1;
      chk("ul_busy", ld_busy, 1);
      chk("ul_lock", buf_lock, 8'h08);
      for (int f = 0; f < 32; f++) sbq.push_back('{{3'd3, 5'(f)}, model[{3'd3, 5'(f)}]});
      while (sbq.size() > 0 && cyc < 300) begin
        ul_ready = (cyc % 2) == 1;
        #1;
        chk("ul_valid", ul_valid, 1);
        chk("ul_data", ul_data, sbq[0].d);
        if (ul_ready) void'(sbq.pop_front());
        step();
        cyc++;
      end
      ul_ready = 0;
      #1;
      chk("ul_left", sbq.size(), 0);
      chk("ul_done", ld_done, 1);
      chk("ul_valid_end", ul_valid, 0);
      chk("ul_busy_end", ld_busy, 0);
      step();
      chk("ul_done_pulse", ld_done, 0);
      sbq.delete();
      // Simultaneous starts: load wins
      ld_start = 1;
      ul_start = 1;
      ld_buf = 3'd6;
      ul_buf = 3'd1;
      step();
      ld_start = 0;
      ul_start = 0;
      #1;
      chk("both_ld_ready", ld_ready, 1);
      chk("both_ul_valid", ul_valid, 0);
      chk("both_lock", buf_lock, 8'h40);
      reset = 0;
      step();
      reset = 1;
      for (int k = 0; k < 256; k++) model[k] = '0;
    end
`endif
    // Load with PAT write priority for 3 cycles
    load(3'd5, 8'h40, 4, 3);
    // Reset during a load aborts it and clears memory
    ld_start = 1;
    ld_buf = 3'd2;
    step();
    ld_start = 0;
    for (int k = 0; k < 10; k++) begin
      ld_valid = 1;
      ld_data = 8'h90 + 8'(k);
      step();
    end
    ld_valid = 0;
    reset = 0;
    step();
    reset = 1;
    #1;
    chk("abort_busy", ld_busy, 0);
    chk("abort_done", ld_done, 0);
    chk("abort_lock", buf_lock, 0);
    for (int k = 0; k < 256; k++) model[k] = '0;
    buf_fieldp = 8'h40;
    #1 chk("abort_clr_b2", field_out, 0);
    buf_fieldp = 8'hA0;
    #1 chk("abort_clr_b5", field_out, 0);
    buf_fieldp = 8'h45;
    #1 chk("abort_clr_pat", field_out, 0);
    step();
    chk("abort_done_late", ld_done, 0);
    load(3'd2, 8'hC0, 1000, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
